imem_access_ctrl: RTL and testbench
===================================

// Module: imem_access_ctrl
// PURPOSE
// - Sequences and shares the single-port instruction memory between the IF stage (fetch) and the program loader/debug port.
// - Handles variable memory latency with a req/ack handshake and raises o_if_stall; the pipeline uses it to deassert clk_en.
// - Delivers the fetched word to the IF stage's i_inst_data.
// - Sits between instruction_fetch and the instruction memory; all memory-side signals are owned by this block.
// PARAMETERS
// - ADDR_WIDTH      32            : address width of all address ports.
// - DATA_WIDTH      32            : instruction/data word width.
// - TIMEOUT_CYCLES  16            : cycles in FETCH/LOAD without i_mem_ack before abort. Legal range 1..255.
// - NOP_INST        32'h0000_0013 : word returned to IF on fetch timeout (addi x0,x0,0).
// PORTS
// - clk             in   1   : main clock, rising edge.
// - rst_n           in   1   : asynchronous active-low reset.
// - i_if_rd_en      in   1   : IF fetch request (o_inst_rd_enable).
// - i_if_addr       in   AW  : current PC (o_inst_addr).
// - i_if_next_addr  in   AW  : PC value loaded on the next enabled edge (PC mux output).
// - i_pipe_stall    in   1   : stall from other pipeline sources; IF does not advance this cycle.
// - o_if_data       out  DW  : instruction to IF, valid when o_if_stall=0.
// - o_if_stall      out  1   : 1 = fetch data not available this cycle.
// - o_fetch_fault   out  1   : 1-cycle pulse on fetch timeout.
// - i_ld_req        in   1   : loader access request, level.
// - i_ld_we         in   1   : 1 = write, 0 = read.
// - i_ld_addr       in   AW  : loader address.
// - i_ld_wdata      in   DW  : loader write data.
// - o_ld_gnt        out  1   : 1-cycle pulse; loader request captured.
// - o_ld_done       out  1   : 1-cycle pulse; loader access finished.
// - o_ld_err        out  1   : qualifies o_ld_done; 1 = timeout.
// - o_ld_rdata      out  DW  : registered read data; held until the next o_ld_done.
// - o_mem_req       out  1   : memory request, held until ack or timeout.
// - o_mem_we        out  1   : memory write enable.
// - o_mem_addr      out  AW  : memory address.
// - o_mem_wdata     out  DW  : memory write data.
// - i_mem_rdata     in   DW  : memory read data, valid with i_mem_ack.
// - i_mem_ack       in   1   : memory completion. May assert in the first cycle of o_mem_req.
// BEHAVIOUR
// - FSM states: IDLE, FETCH, LOAD.
// - Reset: state=IDLE; addr/wdata/we regs=0; timeout counter=0; o_ld_rdata=0; last_grant=LOADER.
//   All outputs are 0, except o_if_data=NOP_INST and o_if_stall=i_if_rd_en.
// - Arbitration points: in IDLE, and in the completion cycle (ack or timeout) of FETCH/LOAD.
//   The next state is entered directly, with no IDLE bubble.
// - Arbitration rule: if only one side requests, it wins. If both request, the side not in last_grant wins.
//   last_grant updates on every grant.
// - Fetch grant address: i_if_next_addr when a fetch completes with delivery in this cycle and i_pipe_stall=0; otherwise i_if_addr.
// - Loader grant: captures i_ld_we/addr/wdata and pulses o_ld_gnt.
//   If i_ld_req is still high after o_ld_done, it is a new request.
// - FETCH state: o_mem_req=1, o_mem_we=0, o_mem_addr=addr_q.
//   Delivery occurs when i_mem_ack=1 and addr_q==i_if_addr:
//     o_if_data=i_mem_rdata (combinational) and o_if_stall=0.
//   On ack with an address mismatch (PC redirected meanwhile), the data is discarded, o_if_stall stays 1, and the block refetches.
// - LOAD state: o_mem_req=1, o_mem_we/addr/wdata from the captured regs.
//   On ack: o_ld_done=1 and o_ld_err=0. On a read, o_ld_rdata<=i_mem_rdata at that edge.
// - o_if_stall = i_if_rd_en && !delivery, in every state.
//   With i_if_rd_en=0, o_if_stall=0 and o_if_data=NOP_INST.
// - Timeout: the counter clears on entry to FETCH/LOAD and increments each cycle without ack.
//   At count==TIMEOUT_CYCLES-1 without ack, the access aborts in that cycle:
//     FETCH: o_if_data=NOP_INST, o_if_stall=0, o_fetch_fault=1. This counts as delivery.
//     LOAD: o_ld_done=1, o_ld_err=1, o_ld_rdata unchanged.
//   An ack in the abort cycle takes precedence over the timeout.
// - Throughput: zero-wait memory with no contention gives 1 fetch per cycle. N wait cycles give N stall cycles per fetch.
// - Reset asserted mid-access: immediate return to reset state. o_mem_req drops asynchronously; the memory must tolerate an abandoned request.
// - i_mem_ack in IDLE is ignored.
// - The memory-side outputs may change only at an arbitration point.
// TESTING
// - Zero-wait ack, i_if_rd_en=1, PC 0x0 -> 0x4 -> 0x8: o_mem_addr follows 0x0/0x4/0x8 on consecutive cycles and o_if_stall stays 0.
// - Memory acks 3 cycles after o_mem_req: o_if_stall=1 for 3 cycles, then 0 with o_if_data=i_mem_rdata; o_mem_addr is constant throughout.
// - Loader write 0x100<=0xDEADBEEF under continuous fetch traffic: o_ld_gnt is granted at the next arbitration point.
//   Fetch and loader then alternate under contention. Read-back returns 0xDEADBEEF on o_ld_rdata with o_ld_done=1, o_ld_err=0.
// - No ack, TIMEOUT_CYCLES=4: in the 4th FETCH cycle, o_if_data=0x00000013, o_if_stall=0, o_fetch_fault pulses once.
//   A loader access in the same condition gives o_ld_done=1, o_ld_err=1.
// - i_if_addr changes 0x10 -> 0x40 during a fetch wait: the ack for 0x10 is discarded and o_mem_addr=0x40 next cycle; delivery only at 0x40.
// - rst_n low mid-LOAD with o_mem_req=1: o_mem_req=0 immediately. After release, the first contention is granted to fetch.

Source files
------------

// File: rtl/imem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_access_ctrl
// Brief    : Shares the single-port instruction memory between IF fetch and the
//            loader port, with req/ack handshake, stall generation and timeout.
// Revision : 1.0
// ============================================================================
module imem_access_ctrl #(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           TIMEOUT_CYCLES = 16,
   parameter logic [DATA_WIDTH-1:0] NOP_INST       = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_if_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   input  logic [ADDR_WIDTH-1:0] i_if_next_addr,
   input  logic                  i_pipe_stall,
   output logic [DATA_WIDTH-1:0] o_if_data,
   output logic                  o_if_stall,
   output logic                  o_fetch_fault,
   input  logic                  i_ld_req,
   input  logic                  i_ld_we,
   input  logic [ADDR_WIDTH-1:0] i_ld_addr,
   input  logic [DATA_WIDTH-1:0] i_ld_wdata,
   output logic                  o_ld_gnt,
   output logic                  o_ld_done,
   output logic                  o_ld_err,
   output logic [DATA_WIDTH-1:0] o_ld_rdata,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic                  i_mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic [7:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_ld_rdata;
   logic                  r_last_ld;
   logic                  r_ld_gnt;

   logic                  w_busy;
   logic                  w_in_fetch;
   logic                  w_in_load;
   logic                  w_timeout;
   logic                  w_done;
   logic                  w_hit;
   logic                  w_deliver;
   logic                  w_arb;
   logic                  w_ld_req;
   logic                  w_gnt_ld;
   logic                  w_gnt_if;
   logic [ADDR_WIDTH-1:0] w_fetch_addr;

   always_comb begin
      w_busy     = (r_state != S_IDLE);
      w_in_fetch = (r_state == S_FETCH);
      w_in_load  = (r_state == S_LOAD);
      w_timeout  = w_busy && !i_mem_ack && (r_cnt == c_to_last);
      w_done     = w_busy && (i_mem_ack || w_timeout);
      // A stale ack (PC redirected meanwhile) completes the access but delivers nothing.
      w_hit      = w_in_fetch && i_mem_ack && (r_addr == i_if_addr);
      w_deliver  = w_hit || (w_in_fetch && w_timeout);
      w_arb      = !w_busy || w_done;
      // The loader's level request in its own completion cycle is the one just served.
      w_ld_req   = i_ld_req && !w_in_load;
      w_gnt_ld   = w_arb && w_ld_req && (!i_if_rd_en || !r_last_ld);
      w_gnt_if   = w_arb && i_if_rd_en && !w_gnt_ld;
      w_fetch_addr = (w_deliver && !i_pipe_stall) ? i_if_next_addr : i_if_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_gnt_ld) begin
         w_state_nxt = S_LOAD;
      end else if (w_gnt_if) begin
         w_state_nxt = S_FETCH;
      end else if (w_arb) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_cnt      <= 8'd0;
         r_ld_rdata <= '0;
         r_last_ld  <= 1'b1;
         r_ld_gnt   <= 1'b0;
      end else begin
         r_ld_gnt <= w_gnt_ld;
         if (w_gnt_ld) begin
            r_addr    <= i_ld_addr;
            r_we      <= i_ld_we;
            r_wdata   <= i_ld_wdata;
            r_last_ld <= 1'b1;
            r_cnt     <= 8'd0;
         end else if (w_gnt_if) begin
            r_addr    <= w_fetch_addr;
            r_we      <= 1'b0;
            r_last_ld <= 1'b0;
            r_cnt     <= 8'd0;
         end else if (w_busy) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_in_load && i_mem_ack && !r_we) begin
            r_ld_rdata <= i_mem_rdata;
         end
      end
   end

   always_comb begin
      o_mem_req     = w_busy;
      o_mem_we      = w_in_load && r_we;
      o_mem_addr    = r_addr;
      o_mem_wdata   = r_wdata;
      o_if_stall    = i_if_rd_en && !w_deliver;
      o_if_data     = (i_if_rd_en && w_hit) ? i_mem_rdata : NOP_INST;
      o_fetch_fault = w_in_fetch && w_timeout;
      o_ld_done     = w_in_load && w_done;
      o_ld_err      = w_in_load && w_timeout;
      o_ld_gnt      = r_ld_gnt;
      o_ld_rdata    = r_ld_rdata;
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_access_ctrl
// Brief    : Directed bench with an access-level reference model and a
//            latency-programmable memory responder.
// Revision : 1.0
// ============================================================================
module tb_imem_access_ctrl;
   localparam int          TO  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_rd_en = 1'b0;
   logic [31:0] pc = 32'd0;
   logic        pipe_stall = 1'b0;
   logic        ld_req = 1'b0;
   logic        ld_we = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [31:0] ld_wdata = 32'd0;
   wire  [31:0] pc_next = pc + 32'd4;

   wire  [31:0] o_if_data, o_ld_rdata, o_mem_addr, o_mem_wdata;
   wire         o_if_stall, o_fetch_fault, o_ld_gnt, o_ld_done, o_ld_err;
   wire         o_mem_req, o_mem_we;

   logic        mem_ack;
   logic [31:0] mem_rdata;
   int          lat = 0;
   logic        ack_force = 1'b0;
   logic [31:0] mem [256];
   bit          mem_ready = 1'b0;

   // reference model: the access currently owning the memory
   bit          m_busy = 1'b0, m_ld = 1'b0, m_we = 1'b0, m_last_ld = 1'b1, m_gnt = 1'b0;
   logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_ld_rdata = 32'd0;
   int          m_age = 0;
   logic        e_to, e_fin, e_hit, e_deliver;
   bit          exp_adv = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   imem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_if_rd_en(if_rd_en), .i_if_addr(pc), .i_if_next_addr(pc_next), .i_pipe_stall(pipe_stall),
      .o_if_data(o_if_data), .o_if_stall(o_if_stall), .o_fetch_fault(o_fetch_fault),
      .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
      .o_ld_gnt(o_ld_gnt), .o_ld_done(o_ld_done), .o_ld_err(o_ld_err), .o_ld_rdata(o_ld_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
   );

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // memory: acks once the current access has waited lat cycles (lat<0 never acks)
   always_comb begin
      mem_ack   = ack_force || (o_mem_req && (lat >= 0) && (m_age == lat));
      mem_rdata = mem[o_mem_addr[9:2]];
   end

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
         mem_ready <= 1'b1;
      end else if (mem_ack && o_mem_req && o_mem_we) begin
         mem[o_mem_addr[9:2]] <= o_mem_wdata;
      end
   end

   always_comb begin
      e_to      = m_busy && !mem_ack && (m_age == TO - 1);
      e_fin     = m_busy && (mem_ack || e_to);
      e_hit     = m_busy && !m_ld && mem_ack && (m_addr == pc);
      e_deliver = e_hit || (m_busy && !m_ld && e_to);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_ld <= 1'b0; m_we <= 1'b0; m_last_ld <= 1'b1; m_gnt <= 1'b0;
         m_addr <= 32'd0; m_wdata <= 32'd0; m_ld_rdata <= 32'd0; m_age <= 0;
      end else begin
         m_gnt <= 1'b0;
         if (m_busy && m_ld && mem_ack && !m_we) m_ld_rdata <= mem[m_addr[9:2]];
         if (!m_busy || e_fin) begin
            if (ld_req && !(m_busy && m_ld) && (!if_rd_en || !m_last_ld)) begin
               m_busy <= 1'b1; m_ld <= 1'b1; m_we <= ld_we; m_addr <= ld_addr;
               m_wdata <= ld_wdata; m_age <= 0; m_last_ld <= 1'b1; m_gnt <= 1'b1;
            end else if (if_rd_en) begin
               m_busy <= 1'b1; m_ld <= 1'b0; m_we <= 1'b0; m_age <= 0; m_last_ld <= 1'b0;
               m_addr <= (e_deliver && !pipe_stall) ? pc_next : pc;
            end else begin
               m_busy <= 1'b0;
            end
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   always @(negedge clk) begin
      chk1("if_stall", o_if_stall, if_rd_en && !e_deliver);
      chk32("if_data", o_if_data, (if_rd_en && e_hit) ? mem[m_addr[9:2]] : NOP);
      chk1("fetch_fault", o_fetch_fault, m_busy && !m_ld && e_to);
      chk1("ld_gnt", o_ld_gnt, m_gnt);
      chk1("ld_done", o_ld_done, m_busy && m_ld && e_fin);
      chk1("ld_err", o_ld_err, m_busy && m_ld && e_to);
      chk32("ld_rdata", o_ld_rdata, m_ld_rdata);
      chk1("mem_req", o_mem_req, m_busy);
      chk1("mem_we", o_mem_we, m_busy && m_ld && m_we);
      if (m_busy) chk32("mem_addr", o_mem_addr, m_addr);
      if (m_busy && m_ld && m_we) chk32("mem_wdata", o_mem_wdata, m_wdata);
      exp_adv = if_rd_en && !pipe_stall && e_deliver;
   end

   task automatic tick();
      bit a;
      @(posedge clk);
      a = exp_adv;
      #1;
      if (a) pc = pc + 32'd4;
   endtask

   task automatic ld_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                            output bit err, output int gnt_at);
      bit g, dn;
      g = 1'b0; dn = 1'b0; err = 1'b0; gnt_at = -1;
      ld_we = we; ld_addr = a; ld_wdata = d; ld_req = 1'b1;
      for (int n = 0; n < 40 && !dn; n++) begin
         @(negedge clk);
         if (o_ld_gnt && !g) begin g = 1'b1; gnt_at = n; end
         if (o_ld_done && g) begin dn = 1'b1; err = o_ld_err; end
         tick();
         if (g) ld_req = 1'b0;
      end
      ld_req = 1'b0;
      if (!dn) begin
         total++; bad++;
         $display("FAIL ld_wait: got no o_ld_done within 40 cycles, expected one");
      end
   endtask

   initial begin
      bit err;
      int gat;
      bit seen;
      // reset state
      if_rd_en = 1'b1;
      @(negedge clk);
      chk1("rst_stall", o_if_stall, 1'b1);
      chk32("rst_data", o_if_data, NOP);
      chk1("rst_req", o_mem_req, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      // zero-wait stream 0x0 -> 0x4 -> 0x8
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk32("seq_addr", o_mem_addr, 32'(4 * k));
         chk1("seq_stall", o_if_stall, 1'b0);
         tick();
      end
      // three wait cycles on the fetch of 0xC
      lat = 3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("wait_stall", o_if_stall, 1'b1);
         chk32("wait_addr", o_mem_addr, 32'h0000_000C);
         tick();
      end
      @(negedge clk);
      chk1("wait_deliver_stall", o_if_stall, 1'b0);
      chk32("wait_deliver_data", o_if_data, 32'hA000_0003);
      tick();
      lat = 0;
      pipe_stall = 1'b1;
      tick(); tick();
      pipe_stall = 1'b0;
      // loader write under fetch traffic, then sustained contention
      ld_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, err, gat);
      chk32("ld_gnt_latency", 32'(gat), 32'd1);
      chk1("ld_wr_err", err, 1'b0);
      ld_we = 1'b0; ld_addr = 32'h0000_0104; ld_req = 1'b1;
      repeat (6) tick();
      ld_req = 1'b0;
      tick(); tick();
      ld_access(1'b0, 32'h0000_0100, 32'd0, err, gat);
      chk1("ld_rd_err", err, 1'b0);
      @(negedge clk);
      chk32("readback", o_ld_rdata, 32'hDEAD_BEEF);
      tick();
      // fetch timeout
      lat = -1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("to_wait_stall", o_if_stall, 1'b1);
         chk1("to_wait_fault", o_fetch_fault, 1'b0);
         tick();
      end
      @(negedge clk);
      chk1("to_stall", o_if_stall, 1'b0);
      chk32("to_data", o_if_data, 32'h0000_0013);
      chk1("to_fault", o_fetch_fault, 1'b1);
      tick();
      @(negedge clk);
      chk1("to_fault_pulse", o_fetch_fault, 1'b0);
      tick();
      ld_access(1'b0, 32'h0000_0104, 32'd0, err, gat);
      chk1("ld_to_err", err, 1'b1);
      @(negedge clk);
      chk32("ld_to_rdata_held", o_ld_rdata, 32'hDEAD_BEEF);
      tick();
      // ack while idle is ignored
      lat = 0; if_rd_en = 1'b0;
      repeat (3) tick();
      ack_force = 1'b1;
      @(negedge clk);
      chk1("idle_ack_req", o_mem_req, 1'b0);
      chk1("idle_ack_done", o_ld_done, 1'b0);
      tick(); tick();
      ack_force = 1'b0;
      // PC redirect 0x10 -> 0x40 during the wait
      pc = 32'h0000_0010; lat = 3; if_rd_en = 1'b1;
      tick(); tick(); tick();
      pc = 32'h0000_0040;
      tick();
      @(negedge clk);
      chk1("redir_discard_stall", o_if_stall, 1'b1);
      tick();
      @(negedge clk);
      chk32("redir_addr", o_mem_addr, 32'h0000_0040);
      tick(); tick(); tick();
      @(negedge clk);
      chk1("redir_stall", o_if_stall, 1'b0);
      chk32("redir_data", o_if_data, 32'hA000_0010);
      tick();
      // reset in the middle of a loader access
      lat = -1; if_rd_en = 1'b0;
      repeat (5) tick();
      ld_we = 1'b1; ld_addr = 32'h0000_0108; ld_wdata = 32'h0000_1234; ld_req = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (o_ld_gnt) seen = 1'b1;
         else tick();
      end
      chk1("rst_mid_gnt_seen", seen, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst_mid_req_drop", o_mem_req, 1'b0);
      ld_we = 1'b0; ld_addr = 32'h0000_0100; if_rd_en = 1'b1; lat = 0; pc = 32'h0000_0020;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk1("post_rst_fetch_we", o_mem_we, 1'b0);
      chk32("post_rst_fetch_addr", o_mem_addr, 32'h0000_0020);
      chk1("post_rst_no_gnt", o_ld_gnt, 1'b0);
      tick();
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (o_ld_done) seen = 1'b1;
         tick();
      end
      ld_req = 1'b0;
      chk1("post_rst_ld_done", seen, 1'b1);
      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at time limit, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
